// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// pipe_ctrl_pkg : hold-level constants and controller state encoding
// Rev 1.0
// ---------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IFID = 3'b010;
  localparam logic [2:0] HOLD_IDEX = 3'b011;
  localparam logic [2:0] HOLD_ALL  = 3'b100;

  localparam int WDT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_wdt.sv
`default_nettype none
// ---------------------------------------------------------------------
// pipe_ctrl_wdt : counts consecutive enabled cycles, flags the LIMIT-th
// Rev 1.0
// ---------------------------------------------------------------------
module pipe_ctrl_wdt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clr,
  output logic expired
);

  localparam logic [WDT_W-1:0] LIMIT_M1 = WDT_W'(LIMIT - 1);

  logic [WDT_W-1:0] cnt;

  // expired fires during the LIMIT-th counted cycle so the FSM leaves on that edge
  assign expired = count_en && (cnt == LIMIT_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (count_en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------
// pipe_ctrl : pipeline hold/flush/jump controller with memory watchdog
// Optional watchdog + FAULT state: define PIPE_CTRL_WDT_EN.   Rev 1.0
// ---------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              load_use_i,
  input  logic              div_start_i,
  input  logic              div_done_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  input  logic              if_ack_i,
  output logic [2:0]        pipe_hold_en_o,
  output logic              flush_o,
  output logic              jump_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              timeout_o
);

  state_t            state, state_nxt;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic [2:0]        hold_raw;
  logic              jump_ok;
  logic              wdt_expired;

`ifdef PIPE_CTRL_WDT_EN
  logic wdt_cnt_en;
  logic wdt_clr;

  assign wdt_cnt_en = (state == ST_MEM_WAIT) && !mem_ack_i;
  assign wdt_clr    = (state != ST_MEM_WAIT);

  pipe_ctrl_wdt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .count_en (wdt_cnt_en),
    .clr      (wdt_clr),
    .expired  (wdt_expired)
  );

  assign timeout_o = (state == ST_FAULT);
`else
  logic unused_cfg;

  assign unused_cfg  = (TIMEOUT_CYC != 0);
  assign wdt_expired = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (mem_req_i && !mem_ack_i) begin
          state_nxt = ST_MEM_WAIT;
        end else if (div_start_i) begin
          state_nxt = ST_DIV_WAIT;
        end
      end
      ST_DIV_WAIT: begin
        if (div_done_i) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          state_nxt = ST_IDLE;
        end else if (wdt_expired) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
`ifdef PIPE_CTRL_WDT_EN
        state_nxt = ST_FAULT;
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ascending priority: the last matching term is the maximum hold level.
  always_comb begin
    hold_raw = HOLD_NONE;
    if (!if_ack_i) begin
      hold_raw = HOLD_PC;
    end
    if (load_use_i) begin
      hold_raw = HOLD_IFID;
    end
    if (((state == ST_DIV_WAIT) && !div_done_i) ||
        ((state == ST_IDLE) && div_start_i)) begin
      hold_raw = HOLD_IDEX;
    end
    if ((mem_req_i && !mem_ack_i) ||
        ((state == ST_MEM_WAIT) && !mem_ack_i) ||
        (state == ST_FAULT)) begin
      hold_raw = HOLD_ALL;
    end
  end

  assign jump_ok = (hold_raw < HOLD_IDEX);

  // A live request is newer than anything pending, so it wins the target.
  always_comb begin
    pipe_hold_en_o = hold_raw;
    jump_o         = 1'b0;
    flush_o        = 1'b0;
    jump_addr_o    = '0;
    if (jump_ok && (jump_req_i || pend_vld)) begin
      jump_o         = 1'b1;
      flush_o        = 1'b1;
      jump_addr_o    = jump_req_i ? jump_addr_i : pend_addr;
      pipe_hold_en_o = if_ack_i ? HOLD_NONE : HOLD_PC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
    end else if (jump_req_i && !jump_ok) begin
      pend_vld  <= 1'b1;
      pend_addr <= jump_addr_i;
    end else if (jump_o) begin
      pend_vld  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl
// Rev 1.0
// ---------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int AW = 64;

  logic          clk;
  logic          rst;
  logic          jump_req_i;
  logic [AW-1:0] jump_addr_i;
  logic          load_use_i;
  logic          div_start_i;
  logic          div_done_i;
  logic          mem_req_i;
  logic          mem_ack_i;
  logic          if_ack_i;
  logic [2:0]    pipe_hold_en_o;
  logic          flush_o;
  logic          jump_o;
  logic [AW-1:0] jump_addr_o;
  logic          timeout_o;

  int checks = 0;
  int errors = 0;
  bit wdt_on;

  pipe_ctrl #(
    .TIMEOUT_CYC (8),
    .ADDR_W      (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_req_i     (jump_req_i),
    .jump_addr_i    (jump_addr_i),
    .load_use_i     (load_use_i),
    .div_start_i    (div_start_i),
    .div_done_i     (div_done_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .if_ack_i       (if_ack_i),
    .pipe_hold_en_o (pipe_hold_en_o),
    .flush_o        (flush_o),
    .jump_o         (jump_o),
    .jump_addr_o    (jump_addr_o),
    .timeout_o      (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    jump_req_i  = 1'b0;
    jump_addr_i = '0;
    load_use_i  = 1'b0;
    div_start_i = 1'b0;
    div_done_i  = 1'b0;
    mem_req_i   = 1'b0;
    mem_ack_i   = 1'b0;
    if_ack_i    = 1'b1;
  endtask

  initial begin
`ifdef PIPE_CTRL_WDT_EN
    wdt_on = 1'b1;
`else
    wdt_on = 1'b0;
`endif
    idle_inputs();
    rst = 1'b1;
    #12;
    chk("rst_hold", 64'(pipe_hold_en_o), 64'd0);
    chk("rst_jump", 64'(jump_o), 64'd0);
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_addr", jump_addr_o, 64'd0);
    chk("rst_tmo", 64'(timeout_o), 64'd0);
    #1 rst = 1'b0;
    nxt();

    // load-use for one cycle
    load_use_i = 1'b1; #1;
    chk("lu_hold", 64'(pipe_hold_en_o), 64'd2);
    nxt(); load_use_i = 1'b0; #1;
    chk("lu_after", 64'(pipe_hold_en_o), 64'd0);

    // fetch not ready
    if_ack_i = 1'b0; #1;
    chk("ifack_hold", 64'(pipe_hold_en_o), 64'd1);
    nxt(); if_ack_i = 1'b1;

    // divider with a jump arriving mid-wait
    div_start_i = 1'b1; #1;
    chk("div_c1_hold", 64'(pipe_hold_en_o), 64'd3);
    for (int c = 2; c <= 6; c++) begin
      nxt();
      div_start_i = 1'b0;
      jump_req_i  = (c == 3);
      jump_addr_i = (c == 3) ? 64'h8000_0040 : 64'h0;
      #1;
      chk("div_wait_hold", 64'(pipe_hold_en_o), 64'd3);
      chk("div_wait_jump", 64'(jump_o), 64'd0);
      chk("div_wait_addr", jump_addr_o, 64'd0);
    end
    nxt(); jump_req_i = 1'b0; jump_addr_i = '0; div_done_i = 1'b1; #1;
    chk("div_done_hold", 64'(pipe_hold_en_o), 64'd0);
    chk("div_done_jump", 64'(jump_o), 64'd1);
    chk("div_done_flush", 64'(flush_o), 64'd1);
    chk("div_done_addr", jump_addr_o, 64'h8000_0040);
    nxt(); div_done_i = 1'b0; #1;
    chk("div_idle_hold", 64'(pipe_hold_en_o), 64'd0);
    chk("div_idle_jump", 64'(jump_o), 64'd0);

    // newer jump overwrites pending target
    div_start_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 64'h0000_1000; #1;
    chk("ovr_jump0", 64'(jump_o), 64'd0);
    nxt(); div_start_i = 1'b0; jump_addr_i = 64'h0000_2000;
    nxt(); jump_req_i = 1'b0; jump_addr_i = '0; div_done_i = 1'b1; #1;
    chk("ovr_addr", jump_addr_o, 64'h0000_2000);
    nxt(); div_done_i = 1'b0;

    // jump beats load-use
    jump_req_i = 1'b1; load_use_i = 1'b1; jump_addr_i = 64'hDEAD_BEEF_0000_1234; #1;
    chk("jlu_jump", 64'(jump_o), 64'd1);
    chk("jlu_flush", 64'(flush_o), 64'd1);
    chk("jlu_hold", 64'(pipe_hold_en_o), 64'd0);
    chk("jlu_addr", jump_addr_o, 64'hDEAD_BEEF_0000_1234);
    if_ack_i = 1'b0; #1;
    chk("jlu_hold_if", 64'(pipe_hold_en_o), 64'd1);
    nxt(); idle_inputs();

    // memory: ack in same cycle, then mem wait beats div start
    mem_req_i = 1'b1; mem_ack_i = 1'b1; #1;
    chk("mem_fast_hold", 64'(pipe_hold_en_o), 64'd0);
    nxt(); mem_ack_i = 1'b0; div_start_i = 1'b1; #1;
    chk("mem_req_hold", 64'(pipe_hold_en_o), 64'd4);
    nxt(); mem_req_i = 1'b0; div_start_i = 1'b0; #1;
    chk("mem_wait_hold", 64'(pipe_hold_en_o), 64'd4);
    mem_ack_i = 1'b1; #1;
    chk("mem_ack_hold", 64'(pipe_hold_en_o), 64'd0);
    nxt(); mem_ack_i = 1'b0; #1;
    chk("mem_idle_hold", 64'(pipe_hold_en_o), 64'd0);

    // watchdog: 8 cycles in MEM_WAIT, then fault
    mem_req_i = 1'b1; #1;
    for (int k = 1; k <= 8; k++) begin
      nxt(); #1;
      chk("wdt_pre_tmo", 64'(timeout_o), 64'd0);
    end
    nxt(); #1;
    chk("wdt_tmo", 64'(timeout_o), wdt_on ? 64'd1 : 64'd0);
    mem_req_i = 1'b0; mem_ack_i = 1'b1; #1;
    chk("wdt_hold", 64'(pipe_hold_en_o), wdt_on ? 64'd4 : 64'd0);
    nxt(); #1;
    chk("wdt_tmo_sticky", 64'(timeout_o), wdt_on ? 64'd1 : 64'd0);
    mem_ack_i = 1'b0;
    #1 rst = 1'b1; #1;
    chk("wdt_rst_tmo", 64'(timeout_o), 64'd0);
    chk("wdt_rst_hold", 64'(pipe_hold_en_o), 64'd0);
    #1 rst = 1'b0;
    nxt();

    // reset during divider wait with a pending jump
    div_start_i = 1'b1;
    nxt(); div_start_i = 1'b0; jump_req_i = 1'b1; jump_addr_i = 64'h0000_0ABC;
    nxt(); jump_req_i = 1'b0; jump_addr_i = '0; #1;
    chk("rdiv_pre_hold", 64'(pipe_hold_en_o), 64'd3);
    #1 rst = 1'b1; #1;
    chk("rdiv_hold", 64'(pipe_hold_en_o), 64'd0);
    chk("rdiv_jump", 64'(jump_o), 64'd0);
    #1 rst = 1'b0;
    nxt(); #1;
    chk("rdiv_post_hold", 64'(pipe_hold_en_o), 64'd0);
    chk("rdiv_post_jump", 64'(jump_o), 64'd0);
    chk("rdiv_post_addr", jump_addr_o, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
